// File: rtl/i2s_tx_multichannel.sv
// Serial audio transmitter (I2S / left-justified / TDM) with a sample FIFO.
// SCLK and LRCLK are derived from Clk by clock-enables; frames are played whole or replaced by zeros.
module i2s_tx_multichannel #(
  parameter int DW       = 24,
  parameter int SLOT     = 32,
  parameter int NCH      = 2,
  parameter int DEPTH    = 16,
  parameter int SCLK_DIV = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     En,
  input  logic [1:0]               Mode,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     level_low,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt,
  output logic                     SCLK,
  output logic                     LRCLK,
  output logic                     SDATA
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FBITS = NCH * SLOT;
  localparam int BW    = $clog2(FBITS);
  localparam int DVW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(FBITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

  stateT state, stateNext;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wrPtr, rdPtr;
  logic [AW:0]     fill;
  logic            push, pop;

  logic [DVW-1:0]  divCnt;
  logic            wrap, fallTick, started, committed, ljPrev;
  logic [BW-1:0]   bitCnt, nextB, slotIdx, slotBit;
  logic            lastBit, stopNow, frameStart, haveFrame, playing, ljBit;
  logic [SLOT-1:0] shReg, shNext, loadWord;

  assign s_ready   = (fill != (AW+1)'(DEPTH));
  assign push      = s_valid & s_ready;
  assign level     = fill;
  assign level_low = (fill <= (AW+1)'(DEPTH / 2));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      if (push && !pop)      fill <= fill + (AW+1)'(1);
      else if (pop && !push) fill <= fill - (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wrPtr] <= s_data;
  end

  assign wrap     = (divCnt == DVW'(SCLK_DIV - 1));
  assign fallTick = wrap & SCLK;
  assign lastBit  = started & (bitCnt == LAST_B);
  // Draining stops at the fall edge that would start a new frame.
  assign stopNow  = (state == DRAIN) & (~started | (fallTick & lastBit));

  assign nextB      = started ? (lastBit ? '0 : bitCnt + BW'(1)) : '0;
  assign slotIdx    = nextB / BW'(SLOT);
  assign slotBit    = nextB % BW'(SLOT);
  assign frameStart = fallTick & (nextB == '0) & ~stopNow;
  assign haveFrame  = (fill >= (AW+1)'(NCH));
  assign playing    = frameStart ? haveFrame : committed;
  assign pop        = fallTick & ~stopNow & (slotBit == '0) & playing;

  // Sample is left-aligned in the slot; the rotate keeps every register bit in use.
  assign loadWord = SLOT'(mem[rdPtr]) << (SLOT - DW);
  assign shNext   = (slotBit == '0) ? (playing ? loadWord : '0)
                                    : {shReg[SLOT-2:0], shReg[SLOT-1]};
  assign ljBit    = shNext[SLOT-1];

  always_ff @(posedge Clk) begin
    if (fallTick) shReg <= shNext;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (En) stateNext = RUN;
      RUN:     if (!En) stateNext = DRAIN;
      DRAIN:   if (stopNow) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      divCnt       <= '0;
      SCLK         <= 1'b0;
      LRCLK        <= 1'b0;
      SDATA        <= 1'b0;
      bitCnt       <= '0;
      started      <= 1'b0;
      committed    <= 1'b0;
      ljPrev       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (state == IDLE || stopNow) begin
        divCnt    <= '0;
        SCLK      <= 1'b0;
        LRCLK     <= 1'b0;
        SDATA     <= 1'b0;
        bitCnt    <= '0;
        started   <= 1'b0;
        committed <= 1'b0;
        ljPrev    <= 1'b0;
      end else begin
        divCnt <= wrap ? '0 : divCnt + DVW'(1);
        if (wrap) SCLK <= ~SCLK;
        if (fallTick) begin
          bitCnt  <= nextB;
          started <= 1'b1;
          ljPrev  <= ljBit;
          // I2S and TDM emit the bit one SCLK late; mode 3 behaves as I2S.
          SDATA   <= (Mode == 2'd1) ? ljBit : ljPrev;
          LRCLK   <= (Mode == 2'd2) ? (nextB == '0) : (slotIdx >= BW'(NCH / 2));
          if (frameStart) begin
            committed <= haveFrame;
            if (!haveFrame) begin
              underrun <= 1'b1;
              if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_multichannel.sv
// Directed bench for i2s_tx_multichannel: a stereo instance and a 4-channel TDM instance
// share clock and reset; serial bits are captured at each SCLK rise and compared as frame words.
module tb_i2s_tx_multichannel;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n;
  logic        en, en4;
  logic [1:0]  mode, mode4;
  logic [23:0] sData, sData4;
  logic        sValid, sValid4, sReady, sReady4;
  logic [4:0]  level, level4;
  logic        levelLow, levelLow4, underrun, underrun4;
  logic [15:0] urCnt, urCnt4;
  logic        sclk, sclk4, lrclk, lrclk4, sdata, sdata4;

  int nChecks  = 0;
  int nErrors  = 0;
  int urPulses = 0;

  localparam logic [127:0] LR2 = {64'h0, 32'hFFFF_FFFF, 32'h0};

  i2s_tx_multichannel #(.DW(24), .SLOT(32), .NCH(2), .DEPTH(16), .SCLK_DIV(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(en), .Mode(mode), .s_data(sData), .s_valid(sValid),
    .s_ready(sReady), .level(level), .level_low(levelLow), .underrun(underrun),
    .underrun_cnt(urCnt), .SCLK(sclk), .LRCLK(lrclk), .SDATA(sdata)
  );

  i2s_tx_multichannel #(.DW(24), .SLOT(32), .NCH(4), .DEPTH(16), .SCLK_DIV(2)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .En(en4), .Mode(mode4), .s_data(sData4), .s_valid(sValid4),
    .s_ready(sReady4), .level(level4), .level_low(levelLow4), .underrun(underrun4),
    .underrun_cnt(urCnt4), .SCLK(sclk4), .LRCLK(lrclk4), .SDATA(sdata4)
  );

  always @(negedge Clk) begin
    if (underrun) urPulses <= urPulses + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Left-justified slot stream: bit b of the word is the bit sent at frame position b.
  function automatic logic [127:0] ljFrame(input logic [95:0] samps, input int nch);
    logic [127:0] w;
    logic [23:0]  s;
    w = '0;
    for (int k = 0; k < nch; k++) begin
      s = samps[k*24 +: 24];
      for (int i = 0; i < 24; i++) w[k*32 + i] = s[23 - i];
    end
    return w;
  endfunction

  function automatic logic [127:0] delay1(input logic [127:0] lj, input int nbits);
    logic [127:0] w;
    w = {lj[126:0], 1'b0};
    for (int i = nbits; i < 128; i++) w[i] = 1'b0;
    return w;
  endfunction

  task automatic captureBits(input bit sel, input int skip, input int n,
                             output logic [127:0] sdW, output logic [127:0] lrW);
    logic prev, cur;
    bit   got;
    sdW  = '0;
    lrW  = '0;
    prev = sel ? sclk4 : sclk;
    for (int i = 0; i < skip + n; i++) begin
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        @(negedge Clk);
        cur  = sel ? sclk4 : sclk;
        got  = cur && !prev;
        prev = cur;
      end
      if (!got) begin
        check("sclk_timeout", 0, 1);
        return;
      end
      if (i >= skip) begin
        sdW[i - skip] = sel ? sdata4 : sdata;
        lrW[i - skip] = sel ? lrclk4 : lrclk;
      end
    end
  endtask

  task automatic pushSample(input bit sel, input logic [23:0] d);
    logic rdy;
    if (sel) begin sData4 = d; sValid4 = 1'b1; end
    else     begin sData  = d; sValid  = 1'b1; end
    rdy = sel ? sReady4 : sReady;
    for (int t = 0; t < 50 && !rdy; t++) begin
      @(negedge Clk);
      rdy = sel ? sReady4 : sReady;
    end
    if (!rdy) check("push_timeout", 0, 1);
    @(negedge Clk);
    if (sel) sValid4 = 1'b0;
    else     sValid  = 1'b0;
  endtask

  task automatic applyReset();
    en = 1'b0; en4 = 1'b0; sValid = 1'b0; sValid4 = 1'b0;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] sdA, lrA, sdB, lrB, lj;
    logic         rdy;
    int           accepted, base;
    bit           seen9;

    Reset_n = 1'b0; en = 1'b0; en4 = 1'b0; mode = 2'd0; mode4 = 2'd2;
    sData = '0; sData4 = '0; sValid = 1'b0; sValid4 = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_sclk", sclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_urcnt", urCnt, 0);
    check("rst_level", level, 0);
    check("rst_level_low", levelLow, 1);
    check("rst_ready", sReady, 1);
    check("rst_ready4", sReady4, 1);
    Reset_n = 1'b1;
    @(negedge Clk);

    // I2S stereo frame, then drain back to idle
    applyReset(); mode = 2'd0;
    pushSample(0, 24'hA5A5A5);
    pushSample(0, 24'h5A5A5A);
    check("i2s_level_pre", level, 2);
    en = 1'b1;
    captureBits(0, 1, 64, sdA, lrA);
    en = 1'b0;
    lj = ljFrame({24'h0, 24'h0, 24'h5A5A5A, 24'hA5A5A5}, 2);
    check("i2s_data", sdA, delay1(lj, 64));
    check("i2s_lrclk", lrA, LR2);
    check("i2s_level_post", level, 0);
    repeat (8) @(negedge Clk);
    check("drain_sclk_idle", sclk, 0);
    check("drain_no_underrun", urCnt, 0);

    // Left-justified: MSB coincides with the LRCLK edge
    applyReset(); mode = 2'd1;
    pushSample(0, 24'hA5A5A5);
    pushSample(0, 24'h5A5A5A);
    en = 1'b1;
    captureBits(0, 1, 64, sdA, lrA);
    en = 1'b0;
    check("lj_data", sdA, ljFrame({24'h0, 24'h0, 24'h5A5A5A, 24'hA5A5A5}, 2));
    check("lj_lrclk", lrA, LR2);

    // Underrun frame with one sample queued, then a full frame
    applyReset(); mode = 2'd0;
    pushSample(0, 24'h800001);
    base = urPulses;
    en = 1'b1;
    captureBits(0, 1, 32, sdA, lrA);
    check("ur_level_kept", level, 1);
    check("ur_cnt", urCnt, 1);
    check("ur_pulses", urPulses - base, 1);
    pushSample(0, 24'h400002);
    captureBits(0, 0, 32, sdB, lrB);
    check("ur_zero_data", {sdB[31:0], sdA[31:0]}, 0);
    check("ur_lrclk", {lrB[31:0], lrA[31:0]}, LR2);
    captureBits(0, 0, 64, sdA, lrA);
    en = 1'b0;
    check("ur_next_data", sdA, delay1(ljFrame({24'h0, 24'h0, 24'h400002, 24'h800001}, 2), 64));
    check("ur_cnt_stays", urCnt, 1);
    check("ur_pulses_stays", urPulses - base, 1);
    check("ur_level_post", level, 0);

    // FIFO full, pop/refill and low-water flag
    applyReset(); mode = 2'd0;
    accepted = 0; sValid = 1'b1; sData = 24'd1;
    repeat (20) begin
      rdy = sReady;
      @(negedge Clk);
      if (rdy) begin
        accepted++;
        sData = 24'(accepted + 1);
      end
    end
    check("full_accepted", accepted, 16);
    check("full_level", level, 16);
    check("full_ready", sReady, 0);
    check("full_level_low", levelLow, 0);
    en = 1'b1;
    for (int t = 0; t < 100 && level == 5'd16; t++) @(negedge Clk);
    check("full_pop_level", level, 15);
    check("full_ready_after_pop", sReady, 1);
    @(negedge Clk);
    check("full_refill_level", level, 16);
    check("full_refill_ready", sReady, 0);
    sValid = 1'b0;
    seen9 = 1'b0;
    for (int t = 0; t < 4000 && level > 5'd8; t++) begin
      @(negedge Clk);
      if (level == 5'd9 && !seen9) begin
        seen9 = 1'b1;
        check("lowmark_above", levelLow, 0);
      end
    end
    check("lowmark_level", level, 8);
    check("lowmark_low", levelLow, 1);
    en = 1'b0;

    // TDM, four channels
    applyReset(); mode4 = 2'd2;
    for (int k = 1; k <= 4; k++) pushSample(1, 24'(k));
    check("tdm_level_pre", level4, 4);
    en4 = 1'b1;
    captureBits(1, 1, 128, sdA, lrA);
    captureBits(1, 0, 1, sdB, lrB);
    en4 = 1'b0;
    check("tdm_data", sdA, delay1(ljFrame({24'd4, 24'd3, 24'd2, 24'd1}, 4), 128));
    check("tdm_lrclk", lrA, 128'h1);
    check("tdm_next_sync", lrB[0], 1);
    check("tdm_next_bit0", sdB[0], 0);
    check("tdm_level_post", level4, 0);
    check("tdm_next_underrun", urCnt4, 1);

    // Asynchronous reset in the middle of a frame
    applyReset(); mode = 2'd0;
    for (int k = 0; k < 5; k++) pushSample(0, 24'hFFFFFF);
    en = 1'b1;
    for (int t = 0; t < 2000 && !(sclk && lrclk && sdata); t++) @(negedge Clk);
    check("midrst_reached", sclk && lrclk && sdata, 1);
    check("midrst_level_before", level, 3);
    Reset_n = 1'b0;
    #1;
    check("midrst_sclk", sclk, 0);
    check("midrst_lrclk", lrclk, 0);
    check("midrst_sdata", sdata, 0);
    check("midrst_level", level, 0);
    @(negedge Clk);
    en = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);
    check("midrst_post_level", level, 0);
    check("midrst_post_ready", sReady, 1);
    check("midrst_post_urcnt", urCnt, 0);
    check("midrst_post_low", levelLow, 1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
